count_sched: RTL and testbench

COUNT_SCHED -- requirements
Module: count_sched

---
 rtl/count_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/count_sched.sv | 161 ++++++++++++++++
 tb/tb_count_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// count_pkg: shared definitions for the count_sched block.
//   state_t  - scheduler FSM state (IDLE / RUN / DONE)
//   CNT_W    - width of the shared up/down counter
//   CNT_MAX  - top of the counter range (saturation point when counting up)
//   CNT_MIN  - bottom of the counter range (saturation point when counting down)
package count_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_MIN = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req - request vector, one bit per requester
//   ptr - index of the requester with highest priority this cycle
//   gnt - one-hot winner (all zero when req is all zero)
// The search starts at ptr and wraps, so the requester at ptr wins first,
// then ptr+1, and so on.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  always_comb begin
    int  idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_sched.sv
// count_sched: arbitrates N_REQ requesters for a shared 8-bit up/down counter
// and issues bursts of counter steps on behalf of the winner.
//   clk        - clock, all state on rising edge
//   rst        - synchronous active-low reset
//   req        - per-requester request level
//   dir        - per-requester direction (1 = up), sampled at grant
//   len        - flattened burst lengths, requester i at [i*LEN_W +: LEN_W]
//   cnt_val    - current counter value, fed back for boundary checks
//   gnt        - one-hot grant, held from first RUN cycle through DONE
//   done       - one-cycle completion pulse on the granted bit
//   err        - one-cycle pulse with done when a burst was truncated
//   busy       - high in RUN and DONE
//   cnt_en     - counter step enable
//   cnt_up     - step direction up (only with cnt_en)
//   cnt_down   - step direction down (only with cnt_en)
//   dbg_state  - current FSM state, encoded as count_pkg::state_t
//
// Handshake: req is a level, not a pulse. A requester sees its grant on gnt
// the cycle after arbitration and keeps it until the cycle its done pulse is
// visible; dropping req mid-burst does not stop the burst, and dir/len are
// only looked at in the arbitration cycle.
module count_sched
  import count_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LEN_W = 4,
  parameter int SAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       dir,
  input  logic [N_REQ*LEN_W-1:0] len,
  input  logic [CNT_W-1:0]       cnt_val,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   err,
  output logic                   busy,
  output logic                   cnt_en,
  output logic                   cnt_up,
  output logic                   cnt_down,
  output logic [1:0]             dbg_state
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [N_REQ-1:0]   gnt_q;
  logic               done_q;
  logic               err_q;
  logic               dir_q;
  logic [LEN_W-1:0]   rem;

  logic [N_REQ-1:0]   win;
  logic               win_dir;
  logic [LEN_W-1:0]   win_len;
  logic [PTR_W-1:0]   nxt_ptr;
  logic               sat_hit;
  logic               step;

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (win)
  );

  // Pull the winner's dir/len out of the flattened inputs and compute the
  // pointer value that puts the winner at lowest priority next time.
  always_comb begin
    win_dir = 1'b0;
    win_len = '0;
    nxt_ptr = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        win_dir = dir[i];
        win_len = len[i*LEN_W +: LEN_W];
        nxt_ptr = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // Boundary check looks at the live counter value so a step that would
  // cross the boundary is suppressed in the same cycle.
  always_comb begin
    sat_hit = 1'b0;
    if (SAT != 0 && state == RUN) begin
      sat_hit = dir_q ? (cnt_val == CNT_MAX) : (cnt_val == CNT_MIN);
    end
  end

  assign step = (state == RUN) && !sat_hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      dir_q  <= 1'b0;
      rem    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_q <= win;
            dir_q <= win_dir;
            rem   <= win_len;
            ptr   <= nxt_ptr;
            if (win_len == '0) begin
              // Zero-length burst: straight to completion, no steps.
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (sat_hit) begin
            state  <= DONE;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            rem <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          gnt_q <= '0;
        end
        default: begin
          state <= IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

  // Outputs are forced low while reset is held, even before the first
  // reset edge has cleared the registers.
  assign gnt       = rst ? gnt_q : '0;
  assign done      = (rst && done_q) ? gnt_q : '0;
  assign err       = rst && done_q && err_q;
  assign busy      = rst && (state != IDLE);
  assign cnt_en    = rst && step;
  assign cnt_up    = rst && step && dir_q;
  assign cnt_down  = rst && step && !dir_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_count_sched.sv
// tb_count_sched: directed bench for count_sched (N_REQ=4, LEN_W=4, SAT=1).
// Every cycle the outputs are packed as
//   {gnt[3:0], done[3:0], err, busy, cnt_en, cnt_up, cnt_down}
// and compared against hand-computed vectors.
module tb_count_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  dir;
  logic [15:0] len;
  logic [7:0]  cnt_val;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        err;
  logic        busy;
  logic        cnt_en;
  logic        cnt_up;
  logic        cnt_down;
  logic [1:0]  dbg_state;

  logic [12:0] obs;
  int          total;
  int          bad;
  logic [3:0]  exp_q[$];

  assign obs = {gnt, done, err, busy, cnt_en, cnt_up, cnt_down};

  count_sched #(
    .N_REQ (4),
    .LEN_W (4),
    .SAT   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dir       (dir),
    .len       (len),
    .cnt_val   (cnt_val),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .cnt_en    (cnt_en),
    .cnt_up    (cnt_up),
    .cnt_down  (cnt_down),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge; inputs change here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] pk(input logic [3:0] g, input logic [3:0] d,
                                     input logic e, input logic b,
                                     input logic en, input logic up,
                                     input logic dn);
    return {g, d, e, b, en, up, dn};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    req     = 4'b1111;
    dir     = 4'b1111;
    len     = 16'h5555;
    cnt_val = 8'd10;
    tick();
    tick();
    #1;
    total++;
    if (obs !== 13'h0) begin
      $display("FAIL reset_outputs: got %h want %h", obs, 13'h0);
      bad++;
    end
    total++;
    if (dbg_state !== 2'd0) begin
      $display("FAIL reset_state: got %0d want 0", dbg_state);
      bad++;
    end
    req = '0;
    rst = 1'b1;
    tick();
  endtask

  // req[0] up, len 3: steps in cycles 1-3, done in cycle 4
  task automatic test_single();
    logic [12:0] exp_t[5];
    exp_t[0] = pk(4'b0001, 4'b0000, 0, 1, 1, 1, 0);
    exp_t[1] = pk(4'b0001, 4'b0000, 0, 1, 1, 1, 0);
    exp_t[2] = pk(4'b0001, 4'b0000, 0, 1, 1, 1, 0);
    exp_t[3] = pk(4'b0001, 4'b0001, 0, 1, 0, 0, 0);
    exp_t[4] = 13'h0;
    do_reset();
    req     = 4'b0001;
    dir     = 4'b0001;
    len     = 16'h0003;
    cnt_val = 8'd10;
    #1;
    total++;
    if (obs !== 13'h0) begin
      $display("FAIL single_arb: got %h want %h", obs, 13'h0);
      bad++;
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin
        // dropping req and changing dir/len must not affect the burst
        req = 4'b0000;
        dir = 4'b0000;
        len = 16'h0000;
      end
      #1;
      total++;
      if (obs !== exp_t[c-1]) begin
        $display("FAIL single_c%0d: got %h want %h", c, obs, exp_t[c-1]);
        bad++;
      end
    end
  endtask

  // all requesting, len 1 each: grants rotate 0,1,2,3,0
  task automatic test_round_robin();
    logic [3:0] e;
    do_reset();
    exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req     = 4'b1111;
    dir     = 4'b1111;
    len     = 16'h1111;
    cnt_val = 8'd10;
    #1;
    for (int g = 0; g < 5; g++) begin
      e = exp_q.pop_front();
      total++;
      if (obs !== 13'h0) begin
        $display("FAIL rr_arb%0d: got %h want %h", g, obs, 13'h0);
        bad++;
      end
      tick();
      #1;
      total++;
      if (obs !== pk(e, 4'b0000, 0, 1, 1, 1, 0)) begin
        $display("FAIL rr_run%0d: got %h want %h", g, obs, pk(e, 4'b0000, 0, 1, 1, 1, 0));
        bad++;
      end
      tick();
      #1;
      total++;
      if (obs !== pk(e, e, 0, 1, 0, 0, 0)) begin
        $display("FAIL rr_done%0d: got %h want %h", g, obs, pk(e, e, 0, 1, 0, 0, 0));
        bad++;
      end
      tick();
      if (g == 4) req = 4'b0000;
    end
  endtask

  // pointer is at 1 after the rotation test: req[1] up from FD, len 5
  task automatic test_sat_up();
    logic [12:0] exp_t[5];
    logic [7:0]  cv[5];
    exp_t[0] = pk(4'b0010, 4'b0000, 0, 1, 1, 1, 0);
    exp_t[1] = pk(4'b0010, 4'b0000, 0, 1, 1, 1, 0);
    exp_t[2] = pk(4'b0010, 4'b0000, 0, 1, 0, 0, 0);
    exp_t[3] = pk(4'b0010, 4'b0010, 1, 1, 0, 0, 0);
    exp_t[4] = 13'h0;
    cv[0] = 8'hFD; cv[1] = 8'hFE; cv[2] = 8'hFF; cv[3] = 8'hFF; cv[4] = 8'hFF;
    tick();
    req     = 4'b0010;
    dir     = 4'b0010;
    len     = 16'h0050;
    cnt_val = 8'hFD;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) req = 4'b0000;
      cnt_val = cv[c-1];
      #1;
      total++;
      if (obs !== exp_t[c-1]) begin
        $display("FAIL sat_up_c%0d: got %h want %h", c, obs, exp_t[c-1]);
        bad++;
      end
    end
  endtask

  // pointer at 2: req[2] down at 0, len 2 -> no steps, done+err next cycle
  task automatic test_sat_down();
    logic [12:0] exp_t[3];
    exp_t[0] = pk(4'b0100, 4'b0000, 0, 1, 0, 0, 0);
    exp_t[1] = pk(4'b0100, 4'b0100, 1, 1, 0, 0, 0);
    exp_t[2] = 13'h0;
    req     = 4'b0100;
    dir     = 4'b0000;
    len     = 16'h0200;
    cnt_val = 8'h00;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) req = 4'b0000;
      #1;
      total++;
      if (obs !== exp_t[c-1]) begin
        $display("FAIL sat_down_c%0d: got %h want %h", c, obs, exp_t[c-1]);
        bad++;
      end
    end
  endtask

  // pointer at 3: req[3] with len 0 -> gnt and done together, no step
  task automatic test_len_zero();
    logic [12:0] exp_t[2];
    exp_t[0] = pk(4'b1000, 4'b1000, 0, 1, 0, 0, 0);
    exp_t[1] = 13'h0;
    req     = 4'b1000;
    dir     = 4'b1000;
    len     = 16'h0000;
    cnt_val = 8'd50;
    for (int c = 1; c <= 2; c++) begin
      tick();
      if (c == 1) req = 4'b0000;
      #1;
      total++;
      if (obs !== exp_t[c-1]) begin
        $display("FAIL len0_c%0d: got %h want %h", c, obs, exp_t[c-1]);
        bad++;
      end
    end
  endtask

  // reset in the second RUN cycle of a len 8 burst, then req[2] beats req[3]
  task automatic test_reset_mid_burst();
    logic [12:0] exp_t[5];
    exp_t[0] = pk(4'b0100, 4'b0000, 0, 1, 1, 1, 0);
    exp_t[1] = pk(4'b0100, 4'b0100, 0, 1, 0, 0, 0);
    exp_t[2] = 13'h0;
    exp_t[3] = pk(4'b1000, 4'b0000, 0, 1, 1, 0, 1);
    exp_t[4] = pk(4'b1000, 4'b1000, 0, 1, 0, 0, 0);
    req     = 4'b0001;
    dir     = 4'b0001;
    len     = 16'h0008;
    cnt_val = 8'd10;
    tick();
    req = 4'b0000;
    #1;
    total++;
    if (obs !== pk(4'b0001, 4'b0000, 0, 1, 1, 1, 0)) begin
      $display("FAIL rst_mid_run1: got %h want %h", obs, pk(4'b0001, 4'b0000, 0, 1, 1, 1, 0));
      bad++;
    end
    tick();
    #1;
    total++;
    if (obs !== pk(4'b0001, 4'b0000, 0, 1, 1, 1, 0)) begin
      $display("FAIL rst_mid_run2: got %h want %h", obs, pk(4'b0001, 4'b0000, 0, 1, 1, 1, 0));
      bad++;
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = 4'b1100;
    dir = 4'b0100;
    len = 16'h1100;
    #1;
    total++;
    if (obs !== 13'h0) begin
      $display("FAIL rst_mid_after: got %h want %h", obs, 13'h0);
      bad++;
    end
    total++;
    if (dbg_state !== 2'd0) begin
      $display("FAIL rst_mid_state: got %0d want 0", dbg_state);
      bad++;
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 4) req = 4'b0000;
      #1;
      total++;
      if (obs !== exp_t[c-1]) begin
        $display("FAIL rst_mid_c%0d: got %h want %h", c, obs, exp_t[c-1]);
        bad++;
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    req     = '0;
    dir     = '0;
    len     = '0;
    cnt_val = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_sat_up();
    test_sat_down();
    test_len_zero();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
